// File: rtl/hiscore_upload.sv
// hiscore_upload: serves hps_io upload reads from a second game-RAM port while the core CPU is paused.
// Define HISCORE_UPLOAD_CHECKSUM_EN to expose a 16-bit running byte sum at addresses SIZE and SIZE+1.
module hiscore_upload #(
  parameter int ADDR_W  = 10,
  parameter int SIZE    = 1024,
  parameter int RAM_LAT = 1,
  parameter int SETTLE  = 16
) (
  input  logic              clk_sys,
  input  logic              Reset_I,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAUSE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_READY   = 3'd3,
    S_FETCH   = 3'd4,
    S_PRESENT = 3'd5
  } state_t;

  localparam logic [24:0] SIZE_A    = 25'(SIZE);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);
  localparam logic [1:0]  LAT_LD    = 2'(RAM_LAT - 1);

  state_t              state_r;
  state_t              state_nx_s;
  logic [15:0]         settle_r;
  logic [15:0]         settle_nx_s;
  logic [1:0]          lat_r;
  logic [1:0]          lat_nx_s;
  logic [7:0]          din_r;
  logic [7:0]          din_nx_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_nx_s;
  logic                wait_r;
  logic                busy_r;
  logic                pause_r;
  logic                done_r;
  logic                done_nx_s;
  logic                upload_prev_r;
  logic                upload_rise_s;
  logic                rd_ok_s;
  logic                in_range_s;
  logic                issue_s;

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
  logic [15:0]         sum_r;
  logic [15:0]         sum_nx_s;

  function automatic logic [7:0] oob_byte(input logic [24:0] addr, input logic [15:0] sum);
    logic [7:0] res;
    if (addr == SIZE_A) begin
      res = sum[7:0];
    end else if (addr == (SIZE_A + 25'd1)) begin
      res = sum[15:8];
    end else begin
      res = 8'hFF;
    end
    return res;
  endfunction
`endif

  assign upload_rise_s = ioctl_upload & ~upload_prev_r;
  assign rd_ok_s       = Reset_I & ioctl_upload & ioctl_rd &
                         ((state_r == S_READY) | (state_r == S_PRESENT));
  assign in_range_s    = (ioctl_addr < SIZE_A);
  assign issue_s       = rd_ok_s & in_range_s;

  // The read request reaches the RAM in the strobe cycle so data returns RAM_LAT+1 cycles after ioctl_rd.
  assign ram_rd     = issue_s;
  assign ram_addr   = issue_s ? ioctl_addr[ADDR_W-1:0] : addr_r;
  assign ioctl_wait = wait_r | issue_s;
  assign ioctl_din  = din_r;
  assign pause_req  = pause_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // Next-state and datapath decisions for the upload session FSM.
  always_comb begin
    state_nx_s  = state_r;
    settle_nx_s = settle_r;
    lat_nx_s    = lat_r;
    din_nx_s    = din_r;
    addr_nx_s   = addr_r;
    done_nx_s   = 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    sum_nx_s    = sum_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (upload_rise_s) begin
          state_nx_s = S_PAUSE;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
          sum_nx_s   = 16'h0000;
`endif
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (!ioctl_upload) begin
          state_nx_s = S_IDLE;
        end else if (pause_ack) begin
          settle_nx_s = SETTLE_LD;
          state_nx_s  = S_SETTLE;
        end else begin
          state_nx_s = S_PAUSE;
        end
      end
      S_SETTLE: begin
        if (!ioctl_upload) begin
          state_nx_s = S_IDLE;
        end else if (settle_r == 16'd0) begin
          state_nx_s = S_READY;
        end else begin
          settle_nx_s = settle_r - 16'd1;
        end
      end
      S_READY, S_PRESENT: begin
        if (!ioctl_upload) begin
          state_nx_s = S_IDLE;
          done_nx_s  = (state_r == S_READY);
        end else if (issue_s) begin
          state_nx_s = S_FETCH;
          lat_nx_s   = LAT_LD;
          addr_nx_s  = ioctl_addr[ADDR_W-1:0];
        end else if (ioctl_rd) begin
          state_nx_s = S_READY;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
          din_nx_s   = oob_byte(ioctl_addr, sum_r);
`else
          din_nx_s   = 8'hFF;
`endif
        end else begin
          state_nx_s = S_READY;
        end
      end
      S_FETCH: begin
        if (!ioctl_upload) begin
          state_nx_s = S_IDLE;
        end else if (lat_r == 2'd0) begin
          din_nx_s   = ram_q;
          state_nx_s = S_PRESENT;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
          sum_nx_s   = sum_r + {8'h00, ram_q};
`endif
        end else begin
          lat_nx_s = lat_r - 2'd1;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; the CPU is held exactly while the FSM is out of IDLE.
  always_ff @(posedge clk_sys) begin
    upload_prev_r <= ioctl_upload;
    if (!Reset_I) begin
      state_r  <= S_IDLE;
      settle_r <= 16'd0;
      lat_r    <= 2'd0;
      din_r    <= 8'h00;
      addr_r   <= '0;
      wait_r   <= 1'b0;
      busy_r   <= 1'b0;
      pause_r  <= 1'b0;
      done_r   <= 1'b0;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_r    <= 16'h0000;
`endif
    end else begin
      state_r  <= state_nx_s;
      settle_r <= settle_nx_s;
      lat_r    <= lat_nx_s;
      din_r    <= din_nx_s;
      addr_r   <= addr_nx_s;
      wait_r   <= (state_nx_s == S_PAUSE) | (state_nx_s == S_SETTLE) | (state_nx_s == S_FETCH);
      busy_r   <= (state_nx_s != S_IDLE);
      pause_r  <= (state_nx_s != S_IDLE);
      done_r   <= done_nx_s;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
      sum_r    <= sum_nx_s;
`endif
    end
  end

endmodule

// File: tb/tb_hiscore_upload.sv
// Self-checking bench for hiscore_upload: directed vector table, corner-case sequences and
// randomized reads against a transaction-level model of the RAM contents and byte sum.
module tb_hiscore_upload;
  localparam int ADDR_W = 10;
  localparam int SIZE   = 1024;
  localparam int LAT    = 1;
  localparam int SETTLE = 16;

  logic              clk_sys = 1'b0;
  logic              Reset_I;
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              pause_req;
  logic              pause_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              busy;
  logic              done;

  always #5 clk_sys = ~clk_sys;

  hiscore_upload #(.ADDR_W(ADDR_W), .SIZE(SIZE), .RAM_LAT(LAT), .SETTLE(SETTLE)) dut (
    .clk_sys(clk_sys), .Reset_I(Reset_I), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .pause_req(pause_req), .pause_ack(pause_ack), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_q(ram_q), .busy(busy), .done(done)
  );

  // Behavioural RAM: data appears LAT cycles after the cycle carrying ram_rd.
  logic [7:0] mem [0:SIZE-1];
  logic [7:0] pipe [LAT];
  always @(posedge clk_sys) begin
    if (ram_rd) pipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_q = pipe[LAT-1];

  int checks = 0;
  int errors = 0;
  logic [15:0] sum_m;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp_din;
    bit          in_rng;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [24:0] a);
    if (a < 25'(SIZE)) return mem[a[ADDR_W-1:0]];
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    if (a == 25'(SIZE)) return sum_m[7:0];
    if (a == 25'(SIZE + 1)) return sum_m[15:8];
`endif
    return 8'hFF;
  endfunction

  task automatic do_read(input logic [24:0] a, output logic [7:0] d, output int w, output int r,
                         output int lt, output logic [ADDR_W-1:0] ra);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    #1;
    w = 0; r = 0; lt = 0; ra = '0;
    if (ioctl_wait) w++;
    if (ram_rd) begin
      r++;
      ra = ram_addr;
    end
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    lt = 1;
    while (ioctl_wait && lt < 20) begin
      w++;
      if (ram_rd) r++;
      @(negedge clk_sys);
      lt++;
    end
    chk("read_timeout", 32'(ioctl_wait), 32'd0);
    d = ioctl_din;
  endtask

  task automatic read_check(input string tag, input logic [24:0] a, input logic [7:0] exp_d,
                            input bit in_rng);
    logic [7:0] d;
    int w, r, lt;
    logic [ADDR_W-1:0] ra;
    do_read(a, d, w, r, lt, ra);
    chk({tag, "_din"}, 32'(d), 32'(exp_d));
    chk({tag, "_wait_cycles"}, 32'(w), in_rng ? 32'(LAT + 1) : 32'd0);
    chk({tag, "_ram_rd_count"}, 32'(r), 32'(in_rng));
    chk({tag, "_latency"}, 32'(lt), in_rng ? 32'(LAT + 1) : 32'd1);
    if (in_rng) begin
      chk({tag, "_ram_addr"}, 32'(ra), 32'(a[ADDR_W-1:0]));
      sum_m = sum_m + 16'(exp_d);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din"}, 32'(ioctl_din), 32'h00);
    chk({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
    chk({tag, "_pause_req"}, 32'(pause_req), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_rd"}, 32'(ram_rd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic start_session(input int ack_delay);
    int n;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    sum_m = 16'h0000;
    @(negedge clk_sys);
    chk("start_pause_req", 32'(pause_req), 32'd1);
    chk("start_wait", 32'(ioctl_wait), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    repeat (ack_delay) @(negedge clk_sys);
    chk("pause_hold_wait", 32'(ioctl_wait), 32'd1);
    pause_ack = 1'b1;
    n = 0;
    while (ioctl_wait && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("settle_cycles", 32'(n), 32'(SETTLE + 1));
  endtask

  task automatic end_session(input bit exp_done);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_pause_req", 32'(pause_req), 32'd0);
    chk("end_wait", 32'(ioctl_wait), 32'd0);
    pause_ack = 1'b0;
    @(negedge clk_sys);
    chk("end_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] a;
    int sel;
    Reset_I = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = 25'd0; pause_ack = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk_sys);
    chk_reset_vals("por");
    Reset_I = 1'b1;

    // Full sequential upload
    start_session(5);
    for (int i = 0; i < SIZE; i++) read_check("seq", 25'(i), 8'(i) ^ 8'h5A, 1'b1);
    end_session(1'b1);

    // Directed vectors, including out-of-range reads
    tbl.push_back('{25'd0,    8'h5A, 1'b1});
    tbl.push_back('{25'd1,    8'h5B, 1'b1});
    tbl.push_back('{25'd90,   8'h00, 1'b1});
    tbl.push_back('{25'd255,  8'hA5, 1'b1});
    tbl.push_back('{25'd256,  8'h5A, 1'b1});
    tbl.push_back('{25'd511,  8'hA5, 1'b1});
    tbl.push_back('{25'd1022, 8'hA4, 1'b1});
    tbl.push_back('{25'd1023, 8'hA5, 1'b1});
    tbl.push_back('{25'd1026, 8'hFF, 1'b0});
    tbl.push_back('{25'd5000, 8'hFF, 1'b0});
    tbl.push_back('{25'h1FFFFFF, 8'hFF, 1'b0});
`ifndef HISCORE_UPLOAD_CHECKSUM_EN
    tbl.push_back('{25'd1024, 8'hFF, 1'b0});
    tbl.push_back('{25'd1025, 8'hFF, 1'b0});
`endif
    start_session(1);
    foreach (tbl[k]) read_check("vec", tbl[k].addr, tbl[k].exp_din, tbl[k].in_rng);

    // pause_ack dropping mid-session changes nothing
    @(negedge clk_sys);
    pause_ack = 1'b0;
    @(negedge clk_sys);
    chk("ackdrop_pause_req", 32'(pause_req), 32'd1);
    chk("ackdrop_busy", 32'(busy), 32'd1);
    read_check("ackdrop", 25'd3, 8'h59, 1'b1);

    // Read latency with a distinctive byte
    mem[7] = 8'hA3;
    read_check("lat7", 25'd7, 8'hA3, 1'b1);
    mem[7] = 8'h5D;
    read_check("prefetch", 25'd10, 8'h50, 1'b1);

    // Upload drops while a RAM read is in flight
    @(negedge clk_sys);
    ioctl_addr = 25'd20; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pause_req", 32'(pause_req), 32'd0);
    chk("abort_wait", 32'(ioctl_wait), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_din_kept", 32'(ioctl_din), 32'h50);
    pause_ack = 1'b0;
    start_session(2);
    read_check("after_abort", 25'd20, 8'h4E, 1'b1);

    // Upload falls and rises in back-to-back cycles
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_idle", 32'(busy), 32'd0);
    @(negedge clk_sys);
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    chk("b2b_restart_pause", 32'(pause_req), 32'd1);
    sel = 0;
    while (ioctl_wait && sel < 100) begin
      @(negedge clk_sys);
      sel++;
    end
    chk("b2b_ready", 32'(ioctl_wait), 32'd0);
    sum_m = 16'h0000;
    read_check("b2b_read", 25'd33, 8'h7B, 1'b1);
    end_session(1'b1);

    // Randomized reads on random RAM contents
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    start_session(int'($urandom_range(0, 6)));
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) a = 25'($urandom_range(0, SIZE - 1));
      else if (sel == 8) a = 25'($urandom_range(SIZE, SIZE + 3));
      else a = 25'($urandom);
      read_check("rnd", a, model_byte(a), a < 25'(SIZE));
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    end
    end_session(1'b1);

    // Reset while a RAM read is in flight
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i) ^ 8'h5A;
    start_session(0);
    read_check("pre_reset", 25'd9, 8'h53, 1'b1);
    @(negedge clk_sys);
    ioctl_addr = 25'd4; ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0; Reset_I = 1'b0; ioctl_upload = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      chk_reset_vals("midreset");
    end
    Reset_I = 1'b1; pause_ack = 1'b0;
    start_session(1);
    read_check("post_reset", 25'd4, 8'h5E, 1'b1);
    end_session(1'b1);

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    // Checksum over an all-0xFF RAM
    for (int i = 0; i < SIZE; i++) mem[i] = 8'hFF;
    start_session(3);
    for (int i = 0; i < SIZE; i++) read_check("ck_seq", 25'(i), 8'hFF, 1'b1);
    read_check("ck_lo", 25'(SIZE), 8'h00, 1'b0);
    read_check("ck_hi", 25'(SIZE + 1), 8'hFC, 1'b0);
    read_check("ck_oob", 25'(SIZE + 2), 8'hFF, 1'b0);
    end_session(1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hiscore_upload.md
Name: hiscore_upload

Overview:
- Serves HPS upload requests (ioctl_upload/ioctl_rd) from an on-core RAM, such as high-score or NVRAM contents. This is the reverse direction of the ROM download path.
- Sits in the emu top between hps_io and a second port of the game RAM.
- Freezes the game CPU through a pause handshake while reading, then streams bytes back to hps_io with ioctl_wait flow control.

Parameters:
- ADDR_W, 10, width of the RAM address.
- SIZE, 1024, number of valid data bytes; must satisfy SIZE <= 2^ADDR_W.
- RAM_LAT, 1, RAM read latency in clk_sys cycles, range 1..3.
- SETTLE, 16, cycles to wait after pause_ack before the first RAM read.

Ports:
- clk_sys  in  1  system clock (12 MHz domain); the only clock.
- Reset_I  in  1  synchronous reset, active-low.
- ioctl_upload  in  1  level; high while the HPS upload session is active.
- ioctl_rd  in  1  single-cycle read strobe from hps_io.
- ioctl_addr  in  25  byte address of the read, valid with ioctl_rd.
- ioctl_din  out  8  read data returned to hps_io.
- ioctl_wait  out  1  high while ioctl_din is not yet valid.
- pause_req  out  1  requests that the core halt its CPU.
- pause_ack  in  1  core reports it is halted.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd  out  1  RAM read enable, one cycle per byte.
- ram_q  in  8  RAM read data, valid RAM_LAT cycles after ram_rd.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse when a session ends normally.

Behaviour:
- All state updates on the rising edge of clk_sys. Reset is synchronous and active-low: Reset_I=0 at an edge returns the block to IDLE.
- Reset values: ioctl_din=8'h00, ioctl_wait=0, pause_req=0, ram_addr=0, ram_rd=0, busy=0, done=0.
- FSM states: IDLE, PAUSE, SETTLE, READY, FETCH, PRESENT.
- IDLE: on a rising edge of ioctl_upload, go to PAUSE and set pause_req=1. ioctl_wait is 1 from this same edge.
- PAUSE: wait for pause_ack=1, then load the settle counter with SETTLE-1 and go to SETTLE. There is no timeout.
- SETTLE: count the counter down to 0, then go to READY and drop ioctl_wait.
- READY: ioctl_wait=0.
  - ioctl_rd=1 with ioctl_addr < SIZE: drive ram_addr=ioctl_addr[ADDR_W-1:0], pulse ram_rd for 1 cycle, raise ioctl_wait in the same cycle, go to FETCH.
  - ioctl_rd=1 with ioctl_addr >= SIZE: no RAM access. ioctl_din=8'hFF on the next edge, ioctl_wait stays 0, stay in READY.
- FETCH: count RAM_LAT cycles after ram_rd. On the edge where ram_q is valid, register ioctl_din=ram_q and go to PRESENT.
- PRESENT: drop ioctl_wait, return to READY. ioctl_din holds its value until the next read.
- Latency: ioctl_rd to valid ioctl_din with ioctl_wait=0 is RAM_LAT+1 cycles. With RAM_LAT=1, ioctl_wait is high for exactly 2 cycles.
- An ioctl_rd that arrives while ioctl_wait=1 is ignored; hps_io never issues one.
- ioctl_upload falls in any non-IDLE state:
  - Abort on that edge: cancel any in-flight RAM read, pause_req=0, ioctl_wait=0, go to IDLE.
  - done pulses only if the state was READY.
- ioctl_upload falls and rises again in back-to-back cycles: the rise is taken only from IDLE, one cycle later.
- pause_ack drops while busy: no effect on the FSM; pause_req stays high.
- Reset mid-session: pause_req drops on the reset edge, and the core resumes.

Optional Feature:
- Macro: HISCORE_UPLOAD_CHECKSUM_EN.
- Enabled:
  - A 16-bit running sum of every byte served from RAM (zero-extended, wrapping modulo 2^16) clears on entry to PAUSE.
  - Reads at address SIZE return sum[7:0]; reads at SIZE+1 return sum[15:8].
  - Neither checksum byte touches the RAM. Addresses >= SIZE+2 return 8'hFF.
  - Re-reading the same address adds to the sum again.
- Disabled: there is no sum logic, and every address >= SIZE returns 8'hFF.

Test Plan:
1. Reset with Reset_I=0 for 3 cycles during active streaming -> all outputs at reset values, pause_req=0 on the first reset edge.
2. RAM preloaded with addr[7:0]^8'h5A; upload with pause_ack after 5 cycles, SETTLE=16; sequential reads 0..1023 -> each ioctl_din equals the expected byte, ioctl_wait high exactly 2 cycles per read, one done pulse when ioctl_upload falls.
3. Read of address 1024 and 5000 (checksum macro disabled) -> ioctl_din=8'hFF, ram_rd never asserted, ioctl_wait stays 0.
4. ioctl_upload drops in FETCH -> next cycle FSM in IDLE, pause_req=0, ioctl_wait=0, no done pulse; a new upload then works normally.
5. Checksum macro enabled, RAM all 8'hFF, SIZE=1024, read all bytes then 1024, 1025 -> 8'h00 then 8'hFC (sum 16'hFC00).
6. RAM_LAT=3 build, read address 7 holding 8'hA3 -> ioctl_din=8'hA3 with ioctl_wait=0 exactly 4 cycles after ioctl_rd.
